// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Sequencing controller for the basketball shooting game.
//               READY countdown -> timed PLAY -> OVER, with PAUSE/abort.
//               Owns the BCD game timer, BCD score and best score, and
//               drives the four display digits, buzzer and status LEDs.
//               Optional feature macro: DOUBLE_SCORE_EN (goals are worth
//               two points once ten or fewer seconds remain).
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int GAME_SECS  = 60,
  parameter int READY_SECS = 3,
  parameter int BUZZ_CYC   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active low
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       goal,
  output logic [3:0] dis3,
  output logic [3:0] dis2,
  output logic [3:0] dis1,
  output logic [3:0] dis0,
  output logic [2:0] state,
  output logic       buzzer,
  output logic       led_play,
  output logic       led_new
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int         BW          = $clog2(BUZZ_CYC + 1);
  localparam logic [7:0] c_game_bcd  = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};
  localparam logic [3:0] c_ready     = 4'(READY_SECS);
  localparam logic [BW-1:0] c_buzz   = BW'(BUZZ_CYC);

  // BCD pair increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)          r = v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD pair decrement; never called with zero
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    ready_cnt_q, ready_cnt_d;
  logic [7:0]    time_q, time_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    best_q, best_d;
  logic          led_new_q, led_new_d;
  logic          led_play_q, led_play_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic [15:0]   dis_q, dis_d;
  logic          w_double;
  logic          w_enter_over;

`ifdef DOUBLE_SCORE_EN
  // Final-ten-seconds bonus; BCD ordering matches numeric ordering
  assign w_double = (time_q <= 8'h10);
`else
  assign w_double = 1'b0;
`endif

  // Next-state and counter update logic
  always_comb begin
    state_d      = state_q;
    ready_cnt_d  = ready_cnt_q;
    time_d       = time_q;
    score_d      = score_q;
    best_d       = best_q;
    led_new_d    = led_new_q;
    w_enter_over = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_READY;
          ready_cnt_d = c_ready;
        end
      end
      ST_READY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ready_cnt_q == 4'd1) begin
            state_d = ST_PLAY;
            time_d  = c_game_bcd;
            score_d = 8'h00;
          end else begin
            ready_cnt_d = ready_cnt_q - 4'd1;
          end
        end
      end
      ST_PLAY: begin
        // A goal counts even alongside stop or the final tick
        if (goal) begin
          score_d = bcd_inc(score_q);
          if (w_double) score_d = bcd_inc(score_d);
        end
        if (stop) begin
          state_d = ST_PAUSE;          // same-cycle tick is dropped
        end else if (tick) begin
          if (time_q == 8'h01) begin
            state_d      = ST_OVER;
            time_d       = 8'h00;
            w_enter_over = 1'b1;
            if (score_d > best_q) begin
              best_d    = score_d;
              led_new_d = 1'b1;
            end
          end else begin
            time_d = bcd_dec(time_q);
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d      = ST_OVER;      // abort: best score untouched
          w_enter_over = 1'b1;
        end else if (start) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start && !stop) begin
          state_d     = ST_READY;
          ready_cnt_d = c_ready;
          led_new_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buzzer length counter: reloads on every OVER entry, otherwise runs down
  always_comb begin
    buzz_cnt_d = buzz_cnt_q;
    if (w_enter_over)           buzz_cnt_d = c_buzz;
    else if (buzz_cnt_q != '0)  buzz_cnt_d = buzz_cnt_q - BW'(1);
  end

  // Display and LED values, built from next-state so outputs align with state
  always_comb begin
    dis_d      = {time_d, score_d};
    led_play_d = (state_d == ST_PLAY);
    if (state_d == ST_READY) dis_d = {12'hFFF, ready_cnt_d};
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ready_cnt_q <= c_ready;
      time_q      <= c_game_bcd;
      score_q     <= 8'h00;
      best_q      <= 8'h00;
      led_new_q   <= 1'b0;
      led_play_q  <= 1'b0;
      buzz_cnt_q  <= '0;
      dis_q       <= {c_game_bcd, 8'h00};
    end else begin
      state_q     <= state_d;
      ready_cnt_q <= ready_cnt_d;
      time_q      <= time_d;
      score_q     <= score_d;
      best_q      <= best_d;
      led_new_q   <= led_new_d;
      led_play_q  <= led_play_d;
      buzz_cnt_q  <= buzz_cnt_d;
      dis_q       <= dis_d;
    end
  end

  assign state    = state_q;
  assign dis3     = dis_q[15:12];
  assign dis2     = dis_q[11:8];
  assign dis1     = dis_q[7:4];
  assign dis0     = dis_q[3:0];
  assign buzzer   = (buzz_cnt_q != '0);
  assign led_play = led_play_q;
  assign led_new  = led_new_q;

endmodule
`default_nettype wire
